pipeline_control: RTL and testbench
===================================

// Module: pipeline_control
// PURPOSE
//  Hazard/sequencing controller for the IF->ID->EX front end. Generates nop bubbles for the decode pipeline register.
//  Also generates PC hold, ID/EX flush, a whole-pipe freeze for data-memory wait, and operand forward selects.
//  Sits beside the decode stage; consumes decode register fields rr1/rr2 plus EX/MEM destination info.
// PARAMETERS
//  REG_W     5   register-index width
//  WAIT_MAX  15  MEM_WAIT cycles before timeout_err sets
//  CNT_W     4   wait-counter width (must hold WAIT_MAX)
// PORTS
//  clk          in   1      processor main clock
//  rst          in   1      asynchronous, active-high reset
//  rr1, rr2     in   REG_W  source regs of instruction in decode stage
//  use1, use2   in   1      instruction in decode actually reads rr1 / rr2
//  ex_rw        in   REG_W  EX-stage destination
//  ex_wr        in   1      EX-stage writes register file
//  ex_load      in   1      EX-stage instruction is a load
//  mem_rw       in   REG_W  MEM-stage destination
//  mem_wr       in   1      MEM-stage writes register file
//  branch_taken in   1      EX resolved taken branch/jump (held by EX while frozen)
//  mem_busy     in   1      data memory not ready
//  pc_en        out  1      1 = PC advances
//  nop          out  1      bubble into decode pipeline register
//  id_ex_flush  out  1      zero the ID/EX register on next edge
//  freeze       out  1      hold every pipeline register and PC
//  fwd_a, fwd_b out  2      operand source: 00 regfile, 10 EX result, 01 MEM result
//  timeout_err  out  1      sticky: MEM_WAIT exceeded WAIT_MAX
// BEHAVIOUR
//  - Clock and reset: one clock (clk). rst is asynchronous and active-high.
//  - While rst=1: state=RUN, wait_cnt=0, timeout_err=0, pc_en=0, nop=1, id_ex_flush=1, freeze=0, fwd=00.
//  - Control outputs are combinational from state + current inputs. The state, wait_cnt and timeout_err are registered.
//  - Hazard test: src hazard = useN & rrN!=0 & rrN==dst & dst_wr. Register x0 never hazards.
//  - States: RUN, LOAD_STALL, FLUSH, FLUSH_HOLD, MEM_WAIT. In RUN, priority is mem_busy > branch_taken > load-use > RAW(no-fwd) > run.
//  - RUN, normal: pc_en=1, other outputs 0 apart from fwd.
//  - RUN->MEM_WAIT on mem_busy: freeze=1, pc_en=0, nop=0.
//    Stay in MEM_WAIT while mem_busy; wait_cnt increments, saturating at WAIT_MAX.
//    timeout_err sets when wait_cnt==WAIT_MAX and is cleared only by rst.
//    Leaving MEM_WAIT: wait_cnt cleared, return to RUN and re-evaluate the same cycle's inputs.
//  - RUN->FLUSH on branch_taken: nop=1, id_ex_flush=1, pc_en=1 for one cycle.
//    FLUSH->FLUSH_HOLD unconditionally. In FLUSH_HOLD: nop=0, pc_en=0, flush=0.
//    FLUSH_HOLD covers the decode register's post-nop recovery edge; the target instruction is re-presented, not lost.
//    Then FLUSH_HOLD->RUN. nop is never asserted two consecutive cycles.
//  - Branch_taken concurrent with a load-use hazard: branch wins (the decode instruction is wrong-path).
//  - RUN->LOAD_STALL on load-use (hazard against ex_rw with ex_load): pc_en=0, id_ex_flush=1, nop=0.
//    The decode register recaptures the same instruction. One cycle, then back to RUN.
//  - Branch_taken arriving in LOAD_STALL goes straight to FLUSH.
//  - mem_busy in any non-RUN state: the current state's outputs are overridden by freeze=1, pc_en=0, nop=0, flush=0.
//    State and wait progress hold until mem_busy drops.
//  - Forward select priority: EX match (ex_wr & !ex_load) over MEM match (mem_wr).
// CONFIGURATION
//  FORWARD_EN defined:
//    - fwd_a/fwd_b per rule above.
//    - Only load-use hazards stall.
//  FORWARD_EN undefined:
//    - fwd_a/fwd_b tied 00.
//    - Any RAW against EX or MEM destination enters LOAD_STALL.
//    - LOAD_STALL repeats each cycle until no hazard remains.
// STRUCTURE
//  Package riscv_ctrl_pkg:
//    - state encodings (3-bit)
//    - FWD_RF=2'b00, FWD_EX=2'b10, FWD_MEM=2'b01
//  Sub-module hazard_detect: combinational comparators producing load_use, raw_ex, raw_mem, fwd_a, fwd_b.
//  FSM and wait counter stay in pipeline_control.
// TESTING
//  1. rst pulse mid-MEM_WAIT (cnt=5) -> state RUN, cnt=0, timeout_err=0 immediately, no clk edge needed.
//  2. ex_load=1, ex_rw=6, rr1=6, use1=1 -> one cycle pc_en=0, id_ex_flush=1, then pc_en=1.
//     With rr1=0 -> no stall.
//  3. branch_taken=1 with load-use pending -> cycle0: nop=1, flush=1, pc_en=1; cycle1: nop=0, pc_en=0; cycle2: RUN.
//  4. mem_busy high for 20 cycles (WAIT_MAX=15) -> freeze=1 throughout, timeout_err=1 from cycle 15, stays 1 after.
//  5. FORWARD_EN: ex_wr=1, ex_rw=3, mem_wr=1, mem_rw=3, rr2=3 -> fwd_b=10, no stall.
//     Without FORWARD_EN -> stall until both clear.
//  6. mem_busy during FLUSH_HOLD for 3 cycles -> outputs frozen, then FLUSH_HOLD completes, then RUN.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the front-end pipeline controller.
//   ctrl_state_e : controller FSM states (3-bit encoding)
//   FWD_*        : operand forward-select encodings
//   fwd_select() : priority encoder for a forward select (EX over MEM)
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_LOAD_STALL = 3'd1,
    ST_FLUSH      = 3'd2,
    ST_FLUSH_HOLD = 3'd3,
    ST_MEM_WAIT   = 3'd4
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  // The EX result is younger than the MEM result, so it wins when both match.
  function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
    if (hit_ex) begin
      return FWD_EX;
    end else if (hit_mem) begin
      return FWD_MEM;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational source/destination comparators for the decode stage.
// Ports:
//   rr1_i, rr2_i, use1_i, use2_i : decode-stage source registers and read enables
//   ex_rw_i, ex_wr_i, ex_load_i  : EX-stage destination, write enable, load flag
//   mem_rw_i, mem_wr_i           : MEM-stage destination, write enable
//   load_use_o                   : a source depends on a load currently in EX
//   raw_ex_o, raw_mem_o          : a source depends on the EX / MEM destination
//   fwd_a_o, fwd_b_o             : forward select per operand (EX over MEM)
// -----------------------------------------------------------------------------
import riscv_ctrl_pkg::*;

module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rr1_i,
  input  logic [REG_W-1:0] rr2_i,
  input  logic             use1_i,
  input  logic             use2_i,
  input  logic [REG_W-1:0] ex_rw_i,
  input  logic             ex_wr_i,
  input  logic             ex_load_i,
  input  logic [REG_W-1:0] mem_rw_i,
  input  logic             mem_wr_i,
  output logic             load_use_o,
  output logic             raw_ex_o,
  output logic             raw_mem_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o
);

  // x0 is hard-wired to zero, so reading it never depends on an older write.
  function automatic logic src_hit(input logic             use_s,
                                   input logic [REG_W-1:0] rr,
                                   input logic [REG_W-1:0] dst,
                                   input logic             wr);
    return use_s && (rr != '0) && (rr == dst) && wr;
  endfunction

  logic a_ex, b_ex, a_mem, b_mem;

  always_comb begin
    a_ex       = src_hit(use1_i, rr1_i, ex_rw_i, ex_wr_i);
    b_ex       = src_hit(use2_i, rr2_i, ex_rw_i, ex_wr_i);
    a_mem      = src_hit(use1_i, rr1_i, mem_rw_i, mem_wr_i);
    b_mem      = src_hit(use2_i, rr2_i, mem_rw_i, mem_wr_i);
    load_use_o = ex_load_i && (a_ex || b_ex);
    raw_ex_o   = a_ex || b_ex;
    raw_mem_o  = a_mem || b_mem;
    // A load's data is not available at the end of EX, so it cannot feed EX.
    fwd_a_o    = fwd_select(a_ex && !ex_load_i, a_mem);
    fwd_b_o    = fwd_select(b_ex && !ex_load_i, b_mem);
  end

endmodule

// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
// Hazard / sequencing controller for the IF->ID->EX front end: PC enable,
// decode-register bubble, ID/EX flush, whole-pipe freeze on data-memory wait,
// and operand forward selects.
// Build option: FORWARD_EN
//   defined   : forward selects active, only load-use hazards stall
//   undefined : forward selects tied to register file, any RAW against the
//               EX or MEM destination stalls until it clears
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   rr1, rr2, use1, use2     : decode-stage sources and read enables
//   ex_rw, ex_wr, ex_load    : EX-stage destination info
//   mem_rw, mem_wr           : MEM-stage destination info
//   branch_taken             : EX resolved a taken branch/jump
//   mem_busy                 : data memory not ready
//   pc_en, nop, id_ex_flush  : PC advance, decode bubble, ID/EX clear
//   freeze                   : hold every pipeline register and the PC
//   fwd_a, fwd_b             : operand sources (00 RF, 10 EX, 01 MEM)
//   timeout_err              : sticky, memory wait reached WAIT_MAX
//   dbg_state, dbg_wait_cnt  : FSM state and wait counter for observation
// Handshake: none; mem_busy is a level that freezes the pipe for every cycle
// it is high, and the controller resumes in the cycle it drops.
// -----------------------------------------------------------------------------
import riscv_ctrl_pkg::*;

module pipeline_control #(
  parameter int REG_W    = 5,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rr1,
  input  logic [REG_W-1:0] rr2,
  input  logic             use1,
  input  logic             use2,
  input  logic [REG_W-1:0] ex_rw,
  input  logic             ex_wr,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rw,
  input  logic             mem_wr,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             nop,
  output logic             id_ex_flush,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             timeout_err,
  output logic [2:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_wait_cnt
);

`ifdef FORWARD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic       load_use, raw_ex, raw_mem, stall_hazard;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       pc_en_c, nop_c, flush_c, freeze_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .rr1_i      (rr1),
    .rr2_i      (rr2),
    .use1_i     (use1),
    .use2_i     (use2),
    .ex_rw_i    (ex_rw),
    .ex_wr_i    (ex_wr),
    .ex_load_i  (ex_load),
    .mem_rw_i   (mem_rw),
    .mem_wr_i   (mem_wr),
    .load_use_o (load_use),
    .raw_ex_o   (raw_ex),
    .raw_mem_o  (raw_mem),
    .fwd_a_o    (fwd_a_raw),
    .fwd_b_o    (fwd_b_raw)
  );

  // Without forwarding every RAW must wait for the write-back to land.
  assign stall_hazard = load_use || (!FWD_ON && (raw_ex || raw_mem));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Hazards detected in RUN are registered into the state; the stall or
  // flush action is driven from that state in the following cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_en_c  = 1'b0;
    nop_c    = 1'b0;
    flush_c  = 1'b0;
    freeze_c = 1'b0;

    if (mem_busy) begin
      // Memory wait overrides every state's outputs. Only RUN starts a new
      // wait; other states keep their place until the memory answers.
      freeze_c = 1'b1;
      if (state_q == ST_RUN) begin
        // The cycle that sees mem_busy is the first waited cycle.
        state_d = ST_MEM_WAIT;
        cnt_d   = CNT_ONE;
      end else if (state_q == ST_MEM_WAIT) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end
    end else begin
      unique case (state_q)
        // MEM_WAIT with memory ready behaves as RUN on the same inputs.
        ST_RUN, ST_MEM_WAIT: begin
          pc_en_c = 1'b1;
          cnt_d   = '0;
          if (branch_taken) begin
            state_d = ST_FLUSH;
          end else if (stall_hazard) begin
            state_d = ST_LOAD_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_LOAD_STALL: begin
          flush_c = 1'b1;
          if (branch_taken) begin
            state_d = ST_FLUSH;
          end else if (!FWD_ON && stall_hazard) begin
            state_d = ST_LOAD_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          pc_en_c = 1'b1;
          nop_c   = 1'b1;
          flush_c = 1'b1;
          state_d = ST_FLUSH_HOLD;
        end
        ST_FLUSH_HOLD: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end

    timeout_d = timeout_q || (cnt_d == CNT_MAX);
  end

  // Reset forces a safe bubble-and-flush output set regardless of inputs.
  always_comb begin
    if (rst) begin
      pc_en       = 1'b0;
      nop         = 1'b1;
      id_ex_flush = 1'b1;
      freeze      = 1'b0;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else begin
      pc_en       = pc_en_c;
      nop         = nop_c;
      id_ex_flush = flush_c;
      freeze      = freeze_c;
      fwd_a       = FWD_ON ? fwd_a_raw : FWD_RF;
      fwd_b       = FWD_ON ? fwd_b_raw : FWD_RF;
    end
  end

  assign timeout_err  = timeout_q;
  assign dbg_state    = state_q;
  assign dbg_wait_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rr1, rr2, ex_rw, mem_rw;
  logic       use1, use2, ex_wr, ex_load, mem_wr, branch_taken, mem_busy;
  logic       pc_en, nop, id_ex_flush, freeze, timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] dbg_state;
  logic [3:0] dbg_wait_cnt;

  localparam logic [7:0] S_RUN = 8'd0, S_LS = 8'd1, S_FL = 8'd2, S_FH = 8'd3, S_MW = 8'd4;

  int checks = 0;
  int errors = 0;

  pipeline_control #(.REG_W(5), .WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rr1(rr1), .rr2(rr2), .use1(use1), .use2(use2),
    .ex_rw(ex_rw), .ex_wr(ex_wr), .ex_load(ex_load),
    .mem_rw(mem_rw), .mem_wr(mem_wr),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .nop(nop), .id_ex_flush(id_ex_flush), .freeze(freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .timeout_err(timeout_err),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    rr1 = '0; rr2 = '0; use1 = 0; use2 = 0;
    ex_rw = '0; ex_wr = 0; ex_load = 0;
    mem_rw = '0; mem_wr = 0; branch_taken = 0; mem_busy = 0;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] st,
                         input logic p, input logic n, input logic f, input logic z);
    chk({tag, ".state"},  8'(dbg_state),   st);
    chk({tag, ".pc_en"},  8'(pc_en),       8'(p));
    chk({tag, ".nop"},    8'(nop),         8'(n));
    chk({tag, ".flush"},  8'(id_ex_flush), 8'(f));
    chk({tag, ".freeze"}, 8'(freeze),      8'(z));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear_inputs();
    #1;
    // reset state
    chk_ctl("rst", S_RUN, 0, 1, 1, 0);
    chk("rst.cnt", 8'(dbg_wait_cnt), 8'd0);
    chk("rst.tmo", 8'(timeout_err), 8'd0);
    chk("rst.fwd", 8'({fwd_a, fwd_b}), 8'd0);
    tick(); tick();
    rst = 0;
    #1;
    chk_ctl("run", S_RUN, 1, 0, 0, 0);

    // load-use on rr1
    ex_load = 1; ex_wr = 1; ex_rw = 5'd6; rr1 = 5'd6; use1 = 1;
    tick();
    chk_ctl("lu1", S_LS, 0, 0, 1, 0);
    ex_load = 0; ex_wr = 0;
    tick();
    chk_ctl("lu1.back", S_RUN, 1, 0, 0, 0);
    // rr1 = x0 never hazards
    ex_load = 1; ex_wr = 1; ex_rw = 5'd0; rr1 = 5'd0; use1 = 1;
    tick();
    chk_ctl("lu.x0", S_RUN, 1, 0, 0, 0);
    // matching register but not read
    ex_rw = 5'd9; rr1 = 5'd9; use1 = 0;
    tick();
    chk_ctl("lu.nouse", S_RUN, 1, 0, 0, 0);
    // load-use on rr2
    rr2 = 5'd9; use2 = 1;
    tick();
    chk_ctl("lu2", S_LS, 0, 0, 1, 0);
    clear_inputs();
    tick();
    chk_ctl("lu2.back", S_RUN, 1, 0, 0, 0);

    // branch with load-use pending: branch wins
    branch_taken = 1; ex_load = 1; ex_wr = 1; ex_rw = 5'd6; rr1 = 5'd6; use1 = 1;
    tick();
    clear_inputs();
    #1;
    chk_ctl("br.c0", S_FL, 1, 1, 1, 0);
    tick();
    chk_ctl("br.c1", S_FH, 0, 0, 0, 0);
    tick();
    chk_ctl("br.c2", S_RUN, 1, 0, 0, 0);

    // mem_busy during FLUSH_HOLD
    branch_taken = 1;
    tick();
    branch_taken = 0;
    tick();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl("fh.frz", S_FH, 0, 0, 0, 1);
      tick();
    end
    mem_busy = 0;
    #1;
    chk_ctl("fh.rel", S_FH, 0, 0, 0, 0);
    tick();
    chk_ctl("fh.run", S_RUN, 1, 0, 0, 0);

    // reset mid MEM_WAIT with cnt=5
    mem_busy = 1;
    #1;
    chk_ctl("mw.c0", S_RUN, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("mw.cnt5", 8'(dbg_wait_cnt), 8'd5);
    chk("mw.state", 8'(dbg_state), S_MW);
    rst = 1;
    #1;
    chk_ctl("mw.rst", S_RUN, 0, 1, 1, 0);
    chk("mw.rst.cnt", 8'(dbg_wait_cnt), 8'd0);
    chk("mw.rst.tmo", 8'(timeout_err), 8'd0);
    mem_busy = 0;
    tick();
    rst = 0;
    #1;
    chk_ctl("mw.after", S_RUN, 1, 0, 0, 0);

    // 20-cycle memory wait, timeout from cycle 15
    mem_busy = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("to.freeze", 8'(freeze), 8'd1);
      chk("to.pc_en", 8'(pc_en), 8'd0);
      chk("to.tmo", 8'(timeout_err), 8'(k >= 15));
      chk("to.cnt", 8'(dbg_wait_cnt), (k > 15) ? 8'd15 : 8'(k));
      tick();
    end
    mem_busy = 0;
    #1;
    chk_ctl("to.exit", S_MW, 1, 0, 0, 0);
    chk("to.sticky", 8'(timeout_err), 8'd1);
    tick();
    chk_ctl("to.run", S_RUN, 1, 0, 0, 0);
    chk("to.cnt0", 8'(dbg_wait_cnt), 8'd0);
    chk("to.sticky2", 8'(timeout_err), 8'd1);

    // RAW against EX and MEM on rr2
    ex_wr = 1; ex_rw = 5'd3; mem_wr = 1; mem_rw = 5'd3; rr2 = 5'd3; use2 = 1;
    rr1 = 5'd3; use1 = 0;
    #1;
`ifdef FORWARD_EN
    chk("fw.b_ex", 8'(fwd_b), 8'h2);
    chk("fw.a_nouse", 8'(fwd_a), 8'h0);
    tick();
    chk_ctl("fw.nostall", S_RUN, 1, 0, 0, 0);
    ex_wr = 0;
    #1;
    chk("fw.b_mem", 8'(fwd_b), 8'h1);
    ex_wr = 1; ex_load = 1;
    #1;
    chk("fw.b_ldmem", 8'(fwd_b), 8'h1);
    tick();
    chk_ctl("fw.ldstall", S_LS, 0, 0, 1, 0);
    clear_inputs();
    tick();
    chk_ctl("fw.back", S_RUN, 1, 0, 0, 0);
`else
    chk("nf.fwd", 8'({fwd_a, fwd_b}), 8'h0);
    tick();
    chk_ctl("nf.s1", S_LS, 0, 0, 1, 0);
    tick();
    chk_ctl("nf.s2", S_LS, 0, 0, 1, 0);
    ex_wr = 0;
    tick();
    chk_ctl("nf.s3", S_LS, 0, 0, 1, 0);
    mem_wr = 0;
    tick();
    chk_ctl("nf.back", S_RUN, 1, 0, 0, 0);
    // x0 destination never stalls
    ex_wr = 1; ex_rw = 5'd0; rr2 = 5'd0; use2 = 1;
    tick();
    chk_ctl("nf.x0", S_RUN, 1, 0, 0, 0);
    clear_inputs();
`endif

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
